// File: rtl/telemetry_framer.sv
// Snapshots WORDS status words and sends them to uart_tx as one packet:
// SYNC, SEQ, LEN, payload (word 0 first, MSB byte first), CHK.
module telemetry_framer #(
   parameter int         WORDS          = 2,
   parameter logic [7:0] SYNC           = 8'hA5,
   parameter int         PERIOD_CYCLES  = 5000000,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [32*WORDS-1:0]  i_words,
   input  logic                 i_force,
   input  logic                 i_tx_active,
   input  logic                 i_tx_done,
   output logic                 o_tx_dv,
   output logic [7:0]           o_tx_byte,
   output logic                 o_busy,
   output logic [7:0]           o_seq,
   output logic [7:0]           o_drop_cnt,
   output logic                 o_timeout_err
);

   localparam int NBYTES = 4*WORDS + 4;
   localparam int PW     = $clog2(PERIOD_CYCLES);
   localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int IW     = $clog2(NBYTES);

   typedef enum logic [1:0] {S_IDLE, S_SNAP, S_ISSUE, S_WAIT} state_t;

   state_t              r_state;
   logic [PW-1:0]       r_period;
   logic                r_pending;
   logic [32*WORDS-1:0] r_buf;
   logic [7:0]          r_sum;
   logic [IW-1:0]       r_idx;
   logic [TW-1:0]       r_wcnt;
   logic                r_tx_dv;
   logic [7:0]          r_tx_byte;
   logic                r_busy;
   logic [7:0]          r_seq;
   logic [7:0]          r_drop;
   logic                r_tmo_err;

   logic                w_wrap;
   logic                w_trig;
   logic                w_last;
   logic [IW-1:0]       w_pidx;
   logic [IW+2:0]       w_bitpos;
   logic [7:0]          w_byte;

   assign w_wrap = (r_period == PW'(PERIOD_CYCLES - 1));
   assign w_trig = w_wrap | i_force;
   assign w_last = (r_idx == IW'(NBYTES - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_period <= '0;
      end else if (w_wrap) begin
         r_period <= '0;
      end else begin
         r_period <= r_period + PW'(1);
      end
   end

   // Payload byte p lives at bit 32*(p/4) + 8*(3 - p%4) of the snapshot.
   always_comb begin
      w_pidx   = r_idx - IW'(3);
      w_bitpos = {w_pidx[IW-1:2], ~w_pidx[1:0], 3'b000};
      w_byte   = 8'(r_buf >> w_bitpos);
      if (r_idx == IW'(0)) begin
         w_byte = SYNC;
      end else if (r_idx == IW'(1)) begin
         w_byte = r_seq;
      end else if (r_idx == IW'(2)) begin
         w_byte = 8'(4*WORDS);
      end else if (w_last) begin
         w_byte = 8'(8'd0 - r_sum);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_pending <= 1'b0;
         r_buf     <= '0;
         r_sum     <= '0;
         r_idx     <= '0;
         r_wcnt    <= '0;
         r_tx_dv   <= 1'b0;
         r_tx_byte <= '0;
         r_busy    <= 1'b0;
         r_seq     <= '0;
         r_drop    <= '0;
         r_tmo_err <= 1'b0;
      end else begin
         r_tx_dv <= 1'b0;
         if (w_trig) begin
            if (r_pending && (r_drop != 8'hFF)) begin
               r_drop <= r_drop + 8'd1;
            end
            r_pending <= 1'b1;
         end
         case (r_state)
            // A trigger in IDLE is acted on in the same cycle it is recorded,
            // so the snapshot lands one cycle after the trigger edge.
            S_IDLE: begin
               if (r_pending || w_trig) begin
                  r_state <= S_SNAP;
               end
            end
            S_SNAP: begin
               r_buf     <= i_words;
               r_seq     <= r_seq + 8'd1;
               r_pending <= w_trig;
               r_sum     <= '0;
               r_idx     <= '0;
               r_busy    <= 1'b1;
               r_state   <= S_ISSUE;
            end
            S_ISSUE: begin
               if (!i_tx_active) begin
                  r_tx_byte <= w_byte;
                  r_tx_dv   <= 1'b1;
                  if ((r_idx != IW'(0)) && !w_last) begin
                     r_sum <= r_sum + w_byte;
                  end
                  r_wcnt  <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_tx_done) begin
                  if (w_last) begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_idx   <= r_idx + IW'(1);
                     r_state <= S_ISSUE;
                  end
               end else if (r_wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_tmo_err <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_wcnt <= r_wcnt + TW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_tx_dv       = r_tx_dv;
   assign o_tx_byte     = r_tx_byte;
   assign o_busy        = r_busy;
   assign o_seq         = r_seq;
   assign o_drop_cnt    = r_drop;
   assign o_timeout_err = r_tmo_err;

endmodule

// File: tb/tb_telemetry_framer.sv
// Randomised bench for telemetry_framer: a UART model answers each byte, and a
// packet-level reference builds every expected frame from the snapshot words.
module tb_telemetry_framer;

   localparam int         WORDS  = 2;
   localparam int         NB     = 4*WORDS + 4;
   localparam int         PERIOD = 6000;
   localparam int         TMO    = 150;
   localparam logic [7:0] SYNC   = 8'hA5;

   logic                clk       = 1'b0;
   logic                rst_n     = 1'b0;
   logic [32*WORDS-1:0] words     = '0;
   logic                frc       = 1'b0;
   logic                tx_active = 1'b0;
   logic                tx_done   = 1'b0;
   logic                tx_dv;
   logic [7:0]          tx_byte;
   logic                busy;
   logic [7:0]          seq;
   logic [7:0]          drop_cnt;
   logic                tmo_err;

   telemetry_framer #(
      .WORDS          (WORDS),
      .SYNC           (SYNC),
      .PERIOD_CYCLES  (PERIOD),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_words       (words),
      .i_force       (frc),
      .i_tx_active   (tx_active),
      .i_tx_done     (tx_done),
      .o_tx_dv       (tx_dv),
      .o_tx_byte     (tx_byte),
      .o_busy        (busy),
      .o_seq         (seq),
      .o_drop_cnt    (drop_cnt),
      .o_timeout_err (tmo_err)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Edges counted since reset release.
   int unsigned cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   logic [7:0]  rx_q[$];
   int unsigned uart_len = 10;
   int unsigned hold_idx = 0;
   int unsigned act_cnt  = 0;
   bit          hold_now = 1'b0;
   logic [7:0]  held_byte = '0;
   logic        prev_dv = 1'b0;
   logic        prev_busy = 1'b0;
   logic        was_active;
   int unsigned rise_cnt = 0, fall_cnt = 0, dv_cnt = 0;
   int unsigned rise_cyc = 0, fall_cyc = 0, done_edge = 0, first_dv_cyc = 0, hold_dv_cyc = 0;

   // UART model and bus monitor; a byte whose number equals hold_idx gets no done pulse.
   always @(negedge clk) begin
      tx_done = 1'b0;
      if (!rst_n) begin
         if (prev_busy) fall_cnt++;
         tx_active = 1'b0;
         act_cnt   = 0;
         hold_now  = 1'b0;
         prev_dv   = 1'b0;
         prev_busy = 1'b0;
         rx_q.delete();
      end else begin
         was_active = tx_active;
         if (busy && !prev_busy) begin
            rise_cnt++;
            rise_cyc = cyc;
            rx_q.delete();
         end
         if (!busy && prev_busy) begin
            fall_cnt++;
            fall_cyc = cyc;
         end
         if (act_cnt > 0) begin
            act_cnt--;
            if (act_cnt == 0) begin
               tx_active = 1'b0;
               if (!hold_now) begin
                  tx_done   = 1'b1;
                  done_edge = cyc + 1;
                  chk("byte_hold", 32'(tx_byte), 32'(held_byte));
               end
               hold_now = 1'b0;
            end
         end
         if (tx_dv) begin
            chk("dv_spacing", 32'(prev_dv), 0);
            chk("dv_uart_idle", 32'(was_active), 0);
            if (rx_q.size() == 0) first_dv_cyc = cyc;
            else chk("dv_gap", cyc, done_edge + 1);
            rx_q.push_back(tx_byte);
            dv_cnt++;
            held_byte = tx_byte;
            tx_active = 1'b1;
            act_cnt   = uart_len;
            if (rx_q.size() == int'(hold_idx)) begin
               hold_now    = 1'b1;
               hold_idx    = 0;
               hold_dv_cyc = cyc;
            end
         end
         prev_dv   = tx_dv;
         prev_busy = busy;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_force(output int unsigned t);
      tick();
      frc = 1'b1;
      t = cyc + 1;
      tick();
      frc = 1'b0;
   endtask

   task automatic wait_rise(input int unsigned target, input int unsigned budget);
      for (int unsigned i = 0; i < budget && rise_cnt < target; i++) tick();
      chk("busy_rise_seen", rise_cnt, target);
   endtask

   task automatic wait_fall(input int unsigned target, input int unsigned budget);
      for (int unsigned i = 0; i < budget && fall_cnt < target; i++) tick();
      chk("busy_fall_seen", fall_cnt, target);
   endtask

   // Reference packet: SYNC, SEQ, LEN, word 0..WORDS-1 MSB byte first, negated sum.
   task automatic check_frame(input string tag, input logic [7:0] s, input logic [32*WORDS-1:0] w);
      logic [7:0]  ex[$];
      logic [7:0]  sm;
      logic [31:0] g;
      ex.push_back(SYNC);
      ex.push_back(s);
      ex.push_back(8'(4*WORDS));
      for (int unsigned k = 0; k < WORDS; k++)
         for (int unsigned b = 0; b < 4; b++)
            ex.push_back(w[32*k + 8*(3-b) +: 8]);
      sm = '0;
      for (int unsigned i = 1; i < NB - 3 + 2; i++) sm = sm + ex[i];
      ex.push_back(8'(8'd0 - sm));
      chk({tag, "_len"}, 32'(rx_q.size()), NB);
      for (int unsigned i = 0; i < NB; i++) begin
         g = 'x;
         if (i < rx_q.size()) g = 32'(rx_q[i]);
         chk($sformatf("%s_b%0d", tag, i), g, 32'(ex[i]));
      end
      sm = '0;
      for (int unsigned i = 1; i < rx_q.size(); i++) sm = sm + rx_q[i];
      chk({tag, "_sum0"}, 32'(sm), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1);
   end

   initial begin
      int unsigned         t;
      int unsigned         nr;
      int unsigned         m_drop;
      logic [7:0]          m_seq;
      logic [32*WORDS-1:0] snap;
      nr = 0; m_drop = 0; m_seq = '0;

      repeat (3) @(negedge clk);
      chk("rst_dv",   32'(tx_dv), 0);
      chk("rst_byte", 32'(tx_byte), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_seq",  32'(seq), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      chk("rst_err",  32'(tmo_err), 0);
      rst_n = 1'b1;

      // Known-vector frame.
      words = {32'h11223344, 32'hAABBCCDD};
      uart_len = 10;
      repeat (4) tick();
      pulse_force(t); m_seq++; snap = words; nr++;
      wait_rise(nr, 10);
      chk("t1_snap_cyc", rise_cyc, t + 1);
      chk("t1_seq", 32'(seq), 32'(m_seq));
      wait_fall(nr, 400);
      chk("t1_first_dv", first_dv_cyc, t + 2);
      chk("t1_busy_fall", fall_cyc, done_edge);
      check_frame("t1", m_seq, snap);

      // Random frames with the input words changed mid-frame.
      for (int unsigned f = 0; f < 5; f++) begin
         words = {$urandom, $urandom};
         uart_len = $urandom_range(5, 25);
         pulse_force(t); m_seq++; snap = words; nr++;
         wait_rise(nr, 10);
         chk("rnd_snap_cyc", rise_cyc, t + 1);
         repeat ($urandom_range(20, 60)) tick();
         words = {$urandom, $urandom};
         wait_fall(nr, 600);
         chk("rnd_first_dv", first_dv_cyc, t + 2);
         chk("rnd_busy_fall", fall_cyc, done_edge);
         check_frame("rnd", m_seq, snap);
         chk("rnd_seq", 32'(seq), 32'(m_seq));
      end

      // Coalesced triggers during a slow frame.
      uart_len = 100;
      pulse_force(t); m_seq++; snap = words; nr++;
      wait_rise(nr, 10);
      repeat (300) tick();
      for (int unsigned k = 0; k < 3; k++) begin
         pulse_force(t);
         repeat (50) tick();
      end
      m_drop += 2;
      wait_fall(nr, 2000);
      check_frame("bb1", m_seq, snap);
      t = done_edge;
      nr++; m_seq++;
      wait_rise(nr, 10);
      chk("bb_snap_cyc", rise_cyc, t + 2);
      wait_fall(nr, 2000);
      check_frame("bb2", m_seq, snap);
      chk("bb_drop", 32'(drop_cnt), m_drop);
      repeat (300) tick();
      chk("bb_no_third", rise_cnt, nr);

      // Periodic frames.
      uart_len = 10;
      for (int unsigned p = 1; p <= 2; p++) begin
         nr++; m_seq++; snap = words;
         wait_rise(nr, PERIOD + 10);
         chk("per_snap_cyc", rise_cyc, p*PERIOD + 1);
         chk("per_seq", 32'(seq), 32'(m_seq));
         wait_fall(nr, 400);
         check_frame("per", m_seq, snap);
      end

      // Withheld done on the third byte.
      hold_idx = 3;
      pulse_force(t); m_seq++; nr++;
      wait_rise(nr, 10);
      for (int unsigned i = 0; i < 400 && !tmo_err; i++) tick();
      chk("tmo_err", 32'(tmo_err), 1);
      chk("tmo_latency", cyc, hold_dv_cyc + TMO);
      chk("tmo_busy", 32'(busy), 0);
      chk("tmo_bytes", 32'(rx_q.size()), 3);
      words = {$urandom, $urandom};
      pulse_force(t); m_seq++; snap = words; nr++;
      wait_rise(nr, 10);
      wait_fall(nr, 400);
      check_frame("after_tmo", m_seq, snap);
      chk("tmo_seq", 32'(seq), 32'(m_seq));
      chk("tmo_sticky", 32'(tmo_err), 1);

      // Asynchronous reset during payload byte 5.
      words = {$urandom, $urandom};
      pulse_force(t); nr++;
      wait_rise(nr, 10);
      for (int unsigned i = 0; i < 400 && rx_q.size() < 8; i++) tick();
      chk("rst_mid_reached", 32'(rx_q.size()), 8);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dv",   32'(tx_dv), 0);
      chk("arst_byte", 32'(tx_byte), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_seq",  32'(seq), 0);
      chk("arst_drop", 32'(drop_cnt), 0);
      chk("arst_err",  32'(tmo_err), 0);
      tick(); tick();
      rst_n = 1'b1;
      m_seq = '0; m_drop = 0;
      t = dv_cnt;
      repeat (200) tick();
      chk("arst_quiet", dv_cnt, t);
      words = {$urandom, $urandom};
      pulse_force(t); m_seq++; snap = words; nr++;
      wait_rise(nr, 10);
      wait_fall(nr, 400);
      check_frame("post_rst", m_seq, snap);
      chk("post_rst_seq", 32'(seq), 1);
      chk("post_rst_drop", 32'(drop_cnt), m_drop);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
